// File: rtl/merge_pkg.sv
// merge_pkg: widths, lane state and helpers shared by the merge accumulator.
// Final CRC inversion is selected by MERGE_FINAL_XOR_EN in merge_acc_lane.
package merge_pkg;

  localparam int CRC_W  = 32;
  localparam int PNUM_W = 4;
  localparam int ZNUM_W = 12;
  localparam int BEAT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } lane_state_e;

  function automatic logic [BEAT_W-1:0] sat_inc(
    input logic [BEAT_W-1:0] b
  );
    return (b == '1) ? b : b + 1'b1;
  endfunction

endpackage

// File: rtl/merge_acc_lane.sv
// merge_acc_lane: one packet lane, XOR-merges partial CRCs from sop to eop.
// MERGE_FINAL_XOR_EN inverts the merged CRC before it is registered out.
module merge_acc_lane
  import merge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sop,
  input  logic              eop,
  input  logic              dval,
  input  logic [PNUM_W-1:0] packet_num,
  input  logic [ZNUM_W-1:0] zero_num,
  input  logic [CRC_W-1:0]  dout,
  output logic              vld,
  output logic              err,
  output logic [PNUM_W-1:0] res_pnum,
  output logic [ZNUM_W-1:0] res_znum,
  output logic [BEAT_W-1:0] res_beats,
  output logic [CRC_W-1:0]  res_crc
);

  lane_state_e       state_q, state_d;
  logic [CRC_W-1:0]  acc_q, acc_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [PNUM_W-1:0] pnum_q, pnum_d;
  logic              emit, fault;
  logic [CRC_W-1:0]  nxt_crc, fin_crc;
  logic [BEAT_W-1:0] nxt_beats;
  logic [PNUM_W-1:0] nxt_pnum;

`ifdef MERGE_FINAL_XOR_EN
  assign fin_crc = nxt_crc ^ {CRC_W{1'b1}};
`else
  assign fin_crc = nxt_crc;
`endif

  // next-state, accumulator update and result selection per beat
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    beats_d   = beats_q;
    pnum_d    = pnum_q;
    emit      = 1'b0;
    fault     = 1'b0;
    nxt_crc   = dout;
    nxt_beats = 8'd1;
    nxt_pnum  = packet_num;
    if (dval) begin
      if (state_q == ACCUM && !sop) begin
        if (eop) begin
          emit      = 1'b1;
          nxt_crc   = acc_q ^ dout;
          nxt_beats = sat_inc(beats_q);
          nxt_pnum  = pnum_q;
          state_d   = IDLE;
        end else begin
          acc_d   = acc_q ^ dout;
          beats_d = sat_inc(beats_q);
        end
      end else if (sop) begin
        // a sop while accumulating abandons the open packet
        fault = (state_q == ACCUM);
        if (eop) begin
          emit    = 1'b1;
          state_d = IDLE;
        end else begin
          acc_d   = dout;
          beats_d = 8'd1;
          pnum_d  = packet_num;
          state_d = ACCUM;
        end
      end else begin
        fault = 1'b1;
      end
    end
  end

  // lane state and running accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      beats_q <= '0;
      pnum_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      pnum_q  <= pnum_d;
    end
  end

  // pulses every cycle, result fields held until the next emit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld       <= 1'b0;
      err       <= 1'b0;
      res_pnum  <= '0;
      res_znum  <= '0;
      res_beats <= '0;
      res_crc   <= '0;
    end else begin
      vld <= emit;
      err <= fault;
      if (emit) begin
        res_pnum  <= nxt_pnum;
        res_znum  <= zero_num;
        res_beats <= nxt_beats;
        res_crc   <= fin_crc;
      end
    end
  end

endmodule

// File: rtl/merge_accumulator.sv
// merge_accumulator: PKT_NUM independent CRC merge lanes.
// MERGE_FINAL_XOR_EN selects final inversion of every merged CRC.
module merge_accumulator
  import merge_pkg::*;
#(
  parameter int PKT_NUM = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PKT_NUM-1:0]         in_sop,
  input  logic [PKT_NUM-1:0]         in_eop,
  input  logic [PKT_NUM-1:0]         in_dval,
  input  logic [PNUM_W*PKT_NUM-1:0]  in_packet_num,
  input  logic [ZNUM_W*PKT_NUM-1:0]  in_zero_num,
  input  logic [CRC_W*PKT_NUM-1:0]   in_dout,
  output logic [PKT_NUM-1:0]         out_vld,
  output logic [PKT_NUM-1:0]         out_err,
  output logic [PNUM_W*PKT_NUM-1:0]  out_packet_num,
  output logic [ZNUM_W*PKT_NUM-1:0]  out_zero_num,
  output logic [BEAT_W*PKT_NUM-1:0]  out_beats,
  output logic [CRC_W*PKT_NUM-1:0]   out_crc
);

  for (genvar i = 0; i < PKT_NUM; i++) begin : g_lane
    merge_acc_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .sop        (in_sop[i]),
      .eop        (in_eop[i]),
      .dval       (in_dval[i]),
      .packet_num (in_packet_num[i*PNUM_W +: PNUM_W]),
      .zero_num   (in_zero_num[i*ZNUM_W +: ZNUM_W]),
      .dout       (in_dout[i*CRC_W +: CRC_W]),
      .vld        (out_vld[i]),
      .err        (out_err[i]),
      .res_pnum   (out_packet_num[i*PNUM_W +: PNUM_W]),
      .res_znum   (out_zero_num[i*ZNUM_W +: ZNUM_W]),
      .res_beats  (out_beats[i*BEAT_W +: BEAT_W]),
      .res_crc    (out_crc[i*CRC_W +: CRC_W])
    );
  end

endmodule

// File: tb/tb_merge_accumulator.sv
// tb_merge_accumulator: directed scenarios for merge_accumulator.
// Expected CRCs follow MERGE_FINAL_XOR_EN when it is defined.
module tb_merge_accumulator;

  localparam int N = 8;
`ifdef MERGE_FINAL_XOR_EN
  localparam logic [31:0] FX = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] FX = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  in_sop, in_eop, in_dval;
  logic [4*N-1:0]  in_packet_num;
  logic [12*N-1:0] in_zero_num;
  logic [32*N-1:0] in_dout;
  logic [N-1:0]  out_vld, out_err;
  logic [4*N-1:0]  out_packet_num;
  logic [12*N-1:0] out_zero_num;
  logic [8*N-1:0]  out_beats;
  logic [32*N-1:0] out_crc;

  int checks = 0;
  int errors = 0;

  merge_accumulator #(.PKT_NUM(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_dval        (in_dval),
    .in_packet_num  (in_packet_num),
    .in_zero_num    (in_zero_num),
    .in_dout        (in_dout),
    .out_vld        (out_vld),
    .out_err        (out_err),
    .out_packet_num (out_packet_num),
    .out_zero_num   (out_zero_num),
    .out_beats      (out_beats),
    .out_crc        (out_crc)
  );

  always #5 clk = ~clk;

  task automatic clear();
    in_sop = '0; in_eop = '0; in_dval = '0;
    in_packet_num = '0; in_zero_num = '0; in_dout = '0;
  endtask

  task automatic beat(input int l, input logic s, input logic e,
                      input logic [3:0] p, input logic [11:0] z,
                      input logic [31:0] d);
    in_dval[l] = 1'b1;
    in_sop[l]  = s;
    in_eop[l]  = e;
    in_packet_num[l*4 +: 4] = p;
    in_zero_num[l*12 +: 12] = z;
    in_dout[l*32 +: 32]     = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear();
  endtask

  task automatic test_reset();
    clear();
    rst = 1'b0;
    step();
    checks++;
    if (out_vld !== '0 || out_err !== '0) begin
      errors++;
      $display("FAIL reset_pulses: vld=%h err=%h want 0", out_vld, out_err);
    end
    checks++;
    if (out_crc !== '0 || out_beats !== '0) begin
      errors++;
      $display("FAIL reset_data: crc=%h beats=%h want 0", out_crc, out_beats);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    beat(0, 1, 1, 4'd3, 12'd5, 32'h1234_5678);
    step();
    checks++;
    if (out_vld !== 8'h01 || out_err !== 8'h00) begin
      errors++;
      $display("FAIL single_vld: vld=%h err=%h want 01/00", out_vld, out_err);
    end
    checks++;
    if (out_crc[31:0] !== (32'h1234_5678 ^ FX)) begin
      errors++;
      $display("FAIL single_crc: got %h want %h", out_crc[31:0], 32'h1234_5678 ^ FX);
    end
    checks++;
    if (out_beats[7:0] !== 8'd1 || out_packet_num[3:0] !== 4'd3 ||
        out_zero_num[11:0] !== 12'd5) begin
      errors++;
      $display("FAIL single_fields: beats=%0d pnum=%0d znum=%0d want 1/3/5",
               out_beats[7:0], out_packet_num[3:0], out_zero_num[11:0]);
    end
    step();
    checks++;
    if (out_vld !== 8'h00 || out_crc[31:0] !== (32'h1234_5678 ^ FX)) begin
      errors++;
      $display("FAIL single_hold: vld=%h crc=%h", out_vld, out_crc[31:0]);
    end
  endtask

  task automatic test_multi_beat();
    beat(2, 1, 0, 4'd9, 12'd0, 32'h0000_000F);
    step();
    checks++;
    if (out_vld !== 8'h00 || out_err !== 8'h00) begin
      errors++;
      $display("FAIL multi_mid: vld=%h err=%h want 00/00", out_vld, out_err);
    end
    beat(2, 0, 0, 4'd1, 12'd0, 32'h0000_00F0);
    step();
    beat(2, 0, 1, 4'd1, 12'd12, 32'h0000_0F00);
    step();
    checks++;
    if (out_vld !== 8'h04 || out_crc[64 +: 32] !== (32'h0000_0FFF ^ FX)) begin
      errors++;
      $display("FAIL multi_crc: vld=%h crc=%h want 04/%h",
               out_vld, out_crc[64 +: 32], 32'h0000_0FFF ^ FX);
    end
    checks++;
    if (out_beats[16 +: 8] !== 8'd3 || out_packet_num[8 +: 4] !== 4'd9 ||
        out_zero_num[24 +: 12] !== 12'd12) begin
      errors++;
      $display("FAIL multi_fields: beats=%0d pnum=%0d znum=%0d want 3/9/12",
               out_beats[16 +: 8], out_packet_num[8 +: 4], out_zero_num[24 +: 12]);
    end
  endtask

  task automatic test_restart();
    beat(1, 1, 0, 4'd2, 12'd0, 32'hAAAA_0000);
    step();
    beat(1, 1, 0, 4'd4, 12'd0, 32'h0000_0001);
    step();
    checks++;
    if (out_err !== 8'h02 || out_vld !== 8'h00) begin
      errors++;
      $display("FAIL restart_err: err=%h vld=%h want 02/00", out_err, out_vld);
    end
    beat(1, 0, 1, 4'd0, 12'd7, 32'h0000_0002);
    step();
    checks++;
    if (out_vld !== 8'h02 || out_err !== 8'h00 ||
        out_crc[32 +: 32] !== (32'h3 ^ FX)) begin
      errors++;
      $display("FAIL restart_done: vld=%h err=%h crc=%h", out_vld, out_err,
               out_crc[32 +: 32]);
    end
    checks++;
    if (out_beats[8 +: 8] !== 8'd2 || out_packet_num[4 +: 4] !== 4'd4) begin
      errors++;
      $display("FAIL restart_fields: beats=%0d pnum=%0d want 2/4",
               out_beats[8 +: 8], out_packet_num[4 +: 4]);
    end
    beat(6, 1, 0, 4'd1, 12'd0, 32'h0000_1111);
    step();
    beat(6, 1, 1, 4'd6, 12'd9, 32'h0000_00AB);
    step();
    checks++;
    if (out_vld !== 8'h40 || out_err !== 8'h40 ||
        out_crc[192 +: 32] !== (32'hAB ^ FX)) begin
      errors++;
      $display("FAIL restart_eop: vld=%h err=%h crc=%h", out_vld, out_err,
               out_crc[192 +: 32]);
    end
  endtask

  task automatic test_orphan();
    beat(5, 0, 1, 4'd7, 12'd3, 32'hDEAD_BEEF);
    step();
    checks++;
    if (out_err !== 8'h20 || out_vld !== 8'h00) begin
      errors++;
      $display("FAIL orphan_err: err=%h vld=%h want 20/00", out_err, out_vld);
    end
    checks++;
    if (out_crc[160 +: 32] !== 32'h0 || out_beats[40 +: 8] !== 8'd0) begin
      errors++;
      $display("FAIL orphan_hold: crc=%h beats=%0d want 0/0",
               out_crc[160 +: 32], out_beats[40 +: 8]);
    end
  endtask

  task automatic test_reset_mid();
    beat(3, 1, 0, 4'd8, 12'd0, 32'h0000_0100);
    step();
    beat(3, 0, 0, 4'd0, 12'd0, 32'h0000_0200);
    rst = 1'b0;
    step();
    checks++;
    if (out_vld !== '0 || out_err !== '0 || out_crc !== '0 ||
        out_beats !== '0 || out_packet_num !== '0 || out_zero_num !== '0) begin
      errors++;
      $display("FAIL rstmid_zero: vld=%h err=%h beats=%h", out_vld, out_err,
               out_beats);
    end
    rst = 1'b1;
    step();
    beat(3, 1, 0, 4'd5, 12'd0, 32'h0000_0100);
    step();
    beat(3, 0, 1, 4'd0, 12'd3, 32'h0000_0011);
    step();
    checks++;
    if (out_vld !== 8'h08 || out_err !== 8'h00 ||
        out_crc[96 +: 32] !== (32'h111 ^ FX)) begin
      errors++;
      $display("FAIL rstmid_fresh: vld=%h err=%h crc=%h", out_vld, out_err,
               out_crc[96 +: 32]);
    end
    checks++;
    if (out_beats[24 +: 8] !== 8'd2 || out_packet_num[12 +: 4] !== 4'd5 ||
        out_zero_num[36 +: 12] !== 12'd3) begin
      errors++;
      $display("FAIL rstmid_fields: beats=%0d pnum=%0d znum=%0d want 2/5/3",
               out_beats[24 +: 8], out_packet_num[12 +: 4], out_zero_num[36 +: 12]);
    end
  endtask

  task automatic test_back_to_back();
    beat(4, 1, 0, 4'd1, 12'd0, 32'h0000_000A);
    step();
    beat(4, 0, 1, 4'd0, 12'd2, 32'h0000_0005);
    step();
    checks++;
    if (out_vld !== 8'h10 || out_crc[128 +: 32] !== (32'hF ^ FX) ||
        out_beats[32 +: 8] !== 8'd2) begin
      errors++;
      $display("FAIL b2b_first: vld=%h crc=%h beats=%0d", out_vld,
               out_crc[128 +: 32], out_beats[32 +: 8]);
    end
    beat(4, 1, 1, 4'd2, 12'd4, 32'h0000_0077);
    step();
    checks++;
    if (out_vld !== 8'h10 || out_err !== 8'h00 ||
        out_crc[128 +: 32] !== (32'h77 ^ FX) || out_beats[32 +: 8] !== 8'd1) begin
      errors++;
      $display("FAIL b2b_second: vld=%h err=%h crc=%h beats=%0d", out_vld,
               out_err, out_crc[128 +: 32], out_beats[32 +: 8]);
    end
  endtask

  task automatic test_saturate();
    beat(7, 1, 0, 4'd15, 12'd0, 32'h1);
    step();
    for (int i = 0; i < 300; i++) begin
      beat(7, 0, 0, 4'd0, 12'd0, 32'h1);
      step();
    end
    beat(7, 0, 1, 4'd0, 12'd1, 32'h1);
    step();
    checks++;
    if (out_vld !== 8'h80 || out_beats[56 +: 8] !== 8'd255 ||
        out_crc[224 +: 32] !== FX) begin
      errors++;
      $display("FAIL saturate: vld=%h beats=%0d crc=%h want 80/255/%h",
               out_vld, out_beats[56 +: 8], out_crc[224 +: 32], FX);
    end
  endtask

  task automatic test_all_lanes();
    logic [3:0] p;
    for (int l = 0; l < N; l++) begin
      p = 4'(l);
      beat(l, 1, 1, p, 12'(l), 32'h0);
    end
    step();
    checks++;
    if (out_vld !== 8'hFF || out_err !== 8'h00) begin
      errors++;
      $display("FAIL all_vld: vld=%h err=%h want FF/00", out_vld, out_err);
    end
    for (int l = 0; l < N; l++) begin
      checks++;
      if (out_crc[l*32 +: 32] !== FX || out_beats[l*8 +: 8] !== 8'd1 ||
          out_packet_num[l*4 +: 4] !== 4'(l)) begin
        errors++;
        $display("FAIL all_lane%0d: crc=%h beats=%0d pnum=%0d want %h/1/%0d",
                 l, out_crc[l*32 +: 32], out_beats[l*8 +: 8],
                 out_packet_num[l*4 +: 4], FX, l);
      end
    end
  endtask

  initial begin
    clear();
    test_reset();
    test_single();
    test_multi_beat();
    test_restart();
    test_orphan();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    test_all_lanes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/merge_accumulator.md
MERGE_ACCUMULATOR -- requirements
Module: merge_accumulator

Interface
REQ-001 SHALL have parameter PKT_NUM, default 8, giving the number of independent packet lanes (matches crossbar output count).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_sop  input  PKT_NUM  per-lane start-of-packet beat flag.
REQ-005 SHALL have port in_eop  input  PKT_NUM  per-lane end-of-packet beat flag.
REQ-006 SHALL have port in_dval  input  PKT_NUM  per-lane beat valid; sop/eop ignored when low.
REQ-007 SHALL have port in_packet_num  input  4*PKT_NUM  per-lane packet tag, lane i at bits [4i+3:4i].
REQ-008 SHALL have port in_zero_num  input  12*PKT_NUM  per-lane tail zero-pad count.
REQ-009 SHALL have port in_dout  input  32*PKT_NUM  per-lane partial CRC of one beat.
REQ-010 SHALL have port out_vld  output  PKT_NUM  one-cycle pulse: merged CRC result ready.
REQ-011 SHALL have port out_err  output  PKT_NUM  one-cycle pulse: framing error on lane.
REQ-012 SHALL have port out_packet_num  output  4*PKT_NUM  tag captured at sop.
REQ-013 SHALL have port out_zero_num  output  12*PKT_NUM  zero count captured at eop.
REQ-014 SHALL have port out_beats  output  8*PKT_NUM  beats merged, saturating at 255.
REQ-015 SHALL have port out_crc  output  32*PKT_NUM  merged CRC.

Function
REQ-016 SHALL process each lane independently with a two-state FSM: IDLE, ACCUM.
REQ-017 IDLE, dval&sop&!eop: acc<=dout, beats<=1, capture packet_num, go ACCUM.
REQ-018 IDLE, dval&sop&eop: emit dout directly as result (beats=1), stay IDLE.
REQ-019 ACCUM, dval&!sop&!eop: acc<=acc^dout, beats<=beats+1 saturating at 255.
REQ-020 ACCUM, dval&!sop&eop: emit acc^dout, beats+1, zero_num of this beat; go IDLE.
REQ-021 ACCUM, dval&sop: pulse out_err, discard accumulation, restart as REQ-017/018 with the new beat.
REQ-022 IDLE, dval&!sop: drop beat, pulse out_err, stay IDLE.
REQ-023 dval low: state, acc, beats unchanged; no pulses.
REQ-024 Result latency SHALL be exactly one cycle: out_vld high the cycle after the eop beat; out_crc/out_packet_num/out_zero_num/out_beats registered and held until next result.
REQ-025 out_vld and out_err SHALL both pulse in the same cycle for REQ-021 when restart beat also carries eop.
REQ-026 Back-to-back packets (eop then sop next cycle) SHALL incur no bubble.

Reset
REQ-027 While rst low: all lanes IDLE; acc, beats, all outputs zero; asynchronous assert, synchronous-to-clk deassert handling by the reset source.
REQ-028 Reset mid-packet SHALL discard the partial accumulation with no out_vld or out_err.

Configuration
REQ-029 Macro MERGE_FINAL_XOR_EN defined: out_crc SHALL equal merged value XOR 32'hFFFFFFFF.
REQ-030 Macro MERGE_FINAL_XOR_EN undefined: out_crc SHALL equal the raw merged value.

Structure
REQ-031 Shared package merge_pkg SHALL hold constants CRC_W=32, PNUM_W=4, ZNUM_W=12, BEAT_W=8, and the lane state enum.
REQ-032 Per-lane logic SHALL be one sub-module merge_acc_lane, instantiated PKT_NUM times in a generate loop.

Verification
REQ-033 Lane 0: single beat sop+eop, dout=32'h12345678, packet_num=3, zero_num=5 -> next cycle out_vld[0]=1, out_crc=32'h12345678 (macro off), beats=1.
REQ-034 Lane 2: three beats 32'h0000000F, 32'h000000F0, 32'h00000F00 (eop, zero_num=12) -> out_crc=32'h00000FFF, beats=3, packet_num from first beat.
REQ-035 Lane 1: sop, then sop again next cycle -> out_err[1] pulse, second packet completes normally.
REQ-036 Lane 5: dval without sop while IDLE -> out_err[5] pulse, outputs unchanged, no out_vld.
REQ-037 Rst low during lane 3 beat 2 of 4 -> no out_vld, all outputs zero; fresh packet after release merges correctly.
REQ-038 All 8 lanes concurrent single-beat packets with MERGE_FINAL_XOR_EN defined, dout=32'h0 -> all out_vld high, each out_crc=32'hFFFFFFFF.
